chan_frame_hdr: RTL and testbench

Framing stage placed directly downstream of the count/data alignment stage in the channelizer datapath. It consumes the count-annotated sample stream (data, 16-bit count, final-count flag, tuser) and emits AXI-Stream frames. Each frame carries a header word, then the samples from count 0 through the final-count sample, with tlast on that last sample. Count continuity is checked inside each frame; a broken frame is closed with an abort word and the block resynchronises on the next count-0 sample.

---
 rtl/chan_frame_hdr_if.sv | 24 ++
 rtl/chan_frame_hdr.sv | 182 ++++++++++++++++++
 tb/tb_chan_frame_hdr.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/chan_frame_hdr_if.sv
// Sample/word stream bundle shared by the framer input and output.
// Input side uses count/final_cnt; output side uses tlast.
interface chan_frame_hdr_if #(
  parameter int DW = 32,
  parameter int TW = 32
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic [TW-1:0] tuser;
  logic          tlast;
  logic [15:0]   count;
  logic          final_cnt;

  modport master (
    output tvalid, tdata, tuser, tlast, count, final_cnt,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tuser, tlast, count, final_cnt,
    output tready
  );
endinterface

// File: rtl/chan_frame_hdr.sv
// Frames count-annotated samples into header + payload AXI-Stream frames,
// aborting frames whose count sequence breaks.
module chan_frame_hdr #(
  parameter int DATA_WIDTH  = 32,
  parameter int TUSER_WIDTH = 32
) (
  input  logic              clk,
  input  logic              sync_reset,
  chan_frame_hdr_if.slave   s_axis,
  chan_frame_hdr_if.master  m_axis,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       err_cnt,
  output logic              seq_err
);

  localparam int DW = DATA_WIDTH;
  localparam int TW = TUSER_WIDTH;
  localparam int WW = DW + TW + 1;

  typedef enum logic [2:0] {
    SEEK, HDR, FIRST, PAYLOAD, ABORT
  } state_t;

  state_t r_state, w_state_nxt;

  logic [WW-1:0] r_mem [2];
  logic          r_rd_ptr, r_wr_ptr;
  logic [1:0]    r_occ;

  logic [DW-1:0] r_h_data;
  logic [TW-1:0] r_h_user;
  logic          r_h_final;
  logic          r_pend;
  logic [15:0]   r_seq;
  logic [15:0]   r_exp;

  logic          w_out_rdy, w_rd, w_wr, w_tready;
  logic [WW-1:0] w_wword, w_rword;
  logic [DW-1:0] w_hdr;
  logic          w_hold_ld, w_pend_set, w_pend_clr;
  logic          w_done, w_err, w_seq_inc;
  logic          w_exp_ld1, w_exp_inc;
  logic          w_unused;

  assign w_out_rdy = (r_occ != 2'd2);
  assign w_rd      = m_axis.tready && m_axis.tvalid;
  assign w_rword   = r_mem[r_rd_ptr];
  assign w_unused  = s_axis.tlast;

  assign s_axis.tready    = w_tready && !sync_reset;
  assign m_axis.tvalid    = (r_occ != 2'd0);
  assign m_axis.tdata     = w_rword[DW-1:0];
  assign m_axis.tuser     = w_rword[DW +: TW];
  assign m_axis.tlast     = w_rword[WW-1];
  assign m_axis.count     = 16'd0;
  assign m_axis.final_cnt = 1'b0;

  always_comb begin
    w_hdr        = '0;
    w_hdr[31:16] = r_seq;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tready    = 1'b0;
    w_wr        = 1'b0;
    w_wword     = '0;
    w_hold_ld   = 1'b0;
    w_pend_set  = 1'b0;
    w_pend_clr  = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_seq_inc   = 1'b0;
    w_exp_ld1   = 1'b0;
    w_exp_inc   = 1'b0;
    case (r_state)
      SEEK: begin
        w_tready = 1'b1;
        if (s_axis.tvalid && s_axis.count == 16'd0) begin
          w_hold_ld   = 1'b1;
          w_state_nxt = HDR;
        end
      end
      HDR: begin
        if (w_out_rdy) begin
          w_wr        = 1'b1;
          w_wword     = {1'b0, r_h_user, w_hdr};
          w_seq_inc   = 1'b1;
          w_state_nxt = FIRST;
        end
      end
      FIRST: begin
        if (w_out_rdy) begin
          w_wr    = 1'b1;
          w_wword = {r_h_final, r_h_user, r_h_data};
          if (r_h_final) begin
            w_done      = 1'b1;
            w_state_nxt = SEEK;
          end else begin
            w_exp_ld1   = 1'b1;
            w_state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        w_tready = w_out_rdy;
        if (s_axis.tvalid && w_out_rdy) begin
          if (s_axis.count == r_exp) begin
            w_wr    = 1'b1;
            w_wword = {s_axis.final_cnt, s_axis.tuser,
                       s_axis.tdata};
            if (s_axis.final_cnt) begin
              w_done      = 1'b1;
              w_state_nxt = SEEK;
            end else begin
              w_exp_inc = 1'b1;
            end
          end else begin
            // a count-0 mismatch is the start of the next frame
            w_err       = 1'b1;
            w_state_nxt = ABORT;
            if (s_axis.count == 16'd0) begin
              w_hold_ld  = 1'b1;
              w_pend_set = 1'b1;
            end
          end
        end
      end
      ABORT: begin
        if (w_out_rdy) begin
          w_wr        = 1'b1;
          w_wword     = {1'b1, {TW{1'b0}}, {DW{1'b1}}};
          w_pend_clr  = 1'b1;
          w_state_nxt = r_pend ? HDR : SEEK;
        end
      end
      default: w_state_nxt = SEEK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_state   <= SEEK;
      r_mem[0]  <= '0;
      r_mem[1]  <= '0;
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_occ     <= 2'd0;
      r_h_data  <= '0;
      r_h_user  <= '0;
      r_h_final <= 1'b0;
      r_pend    <= 1'b0;
      r_seq     <= 16'd0;
      r_exp     <= 16'd0;
      frame_cnt <= 16'd0;
      err_cnt   <= 16'd0;
      seq_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_wword;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_rd) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, w_wr} - {1'b0, w_rd};
      if (w_hold_ld) begin
        r_h_data  <= s_axis.tdata;
        r_h_user  <= s_axis.tuser;
        r_h_final <= s_axis.final_cnt;
      end
      if (w_pend_set)      r_pend <= 1'b1;
      else if (w_pend_clr) r_pend <= 1'b0;
      if (w_seq_inc) r_seq <= r_seq + 16'd1;
      if (w_exp_ld1)      r_exp <= 16'd1;
      else if (w_exp_inc) r_exp <= r_exp + 16'd1;
      if (w_done) frame_cnt <= frame_cnt + 16'd1;
      if (w_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      seq_err <= w_err;
    end
  end

endmodule

// File: tb/tb_chan_frame_hdr.sv
// Directed bench for chan_frame_hdr: framing, resync, abort,
// back-pressure stability and mid-frame reset.
module tb_chan_frame_hdr;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic [15:0] frame_cnt, err_cnt;
  logic        seq_err;

  always #5 clk = ~clk;

  chan_frame_hdr_if s_if ();
  chan_frame_hdr_if m_if ();

  chan_frame_hdr dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt),
    .seq_err    (seq_err)
  );

  typedef struct packed {
    logic        last;
    logic [31:0] user;
    logic [31:0] data;
  } word_t;

  word_t q_exp[$];
  word_t q_got[$];
  word_t prev;
  int    n_chk  = 0;
  int    n_pass = 0;
  int    n_seq  = 0;
  bit    stall  = 0;
  bit    rnd_rdy = 0;

  task automatic chk(input string tag, input logic [64:0] got,
                     input logic [64:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (sync_reset) begin
      stall = 0;
    end else begin
      if (stall) begin
        chk("stall_valid", m_if.tvalid, 1'b1);
        chk("stall_word", {m_if.tlast, m_if.tuser, m_if.tdata}, prev);
      end
      if (m_if.tvalid && m_if.tready)
        q_got.push_back({m_if.tlast, m_if.tuser, m_if.tdata});
      if (seq_err) n_seq++;
      stall = m_if.tvalid && !m_if.tready;
      prev  = {m_if.tlast, m_if.tuser, m_if.tdata};
    end
  end

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic logic [31:0] dv(input int t, input int c);
    return 32'hC000_0000 | ((t & 255) << 16) | (c & 16'hFFFF);
  endfunction

  task automatic send(input int c, input bit f, input logic [31:0] u,
                      input logic [31:0] d);
    int n   = 0;
    bit acc = 0;
    s_if.tvalid    = 1'b1;
    s_if.count     = 16'(c);
    s_if.final_cnt = f;
    s_if.tuser     = u;
    s_if.tdata     = d;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_if.tready;
      @(posedge clk);
      #1;
      n++;
    end
    s_if.tvalid = 1'b0;
    if (!acc) chk("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic ehdr(input int seq, input logic [31:0] u);
    q_exp.push_back({1'b0, u, 16'(seq), 16'h0000});
  endtask

  task automatic esmp(input bit l, input logic [31:0] u,
                      input logic [31:0] d);
    q_exp.push_back({l, u, d});
  endtask

  task automatic eabort();
    q_exp.push_back({1'b1, 32'h0, 32'hFFFF_FFFF});
  endtask

  task automatic frame(input int t, input int len,
                       input logic [31:0] u0, input int seq);
    logic [31:0] u;
    ehdr(seq, u0);
    for (int c = 0; c < len; c++) begin
      u = (c == 0) ? u0 : 32'(c);
      esmp(c == len - 1, u, dv(t, c));
      send(c, c == len - 1, u, dv(t, c));
    end
  endtask

  task automatic drain();
    int idle = 0;
    int n    = 0;
    while (idle < 4 && n < 50000) begin
      @(negedge clk);
      idle = m_if.tvalid ? 0 : idle + 1;
      n++;
    end
    if (idle < 4) chk("drain_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag);
    int n;
    chk({tag, "_len"}, 65'(q_got.size()), 65'(q_exp.size()));
    n = (q_got.size() < q_exp.size()) ? q_got.size() : q_exp.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s[%0d]", tag, i), q_got[i], q_exp[i]);
    q_got.delete();
    q_exp.delete();
  endtask

  initial begin
    s_if.tvalid    = 1'b0;
    s_if.tdata     = '0;
    s_if.tuser     = '0;
    s_if.tlast     = 1'b0;
    s_if.count     = '0;
    s_if.final_cnt = 1'b0;
    sync_reset     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", s_if.tready, 1'b0);
    chk("rst_m_tvalid", m_if.tvalid, 1'b0);
    chk("rst_m_tdata", m_if.tdata, 32'h0);
    chk("rst_m_tuser", m_if.tuser, 32'h0);
    chk("rst_m_tlast", m_if.tlast, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 16'h0);
    chk("rst_err_cnt", err_cnt, 16'h0);
    chk("rst_seq_err", seq_err, 1'b0);
    @(posedge clk);
    #1;
    sync_reset = 1'b0;
    @(negedge clk);
    chk("seek_s_tready", s_if.tready, 1'b1);
    @(posedge clk);
    #1;

    // two length-4 frames
    frame(1, 4, 32'h55, 0);
    drain();
    cmp("t1a");
    chk("t1a_frame_cnt", frame_cnt, 16'd1);
    frame(2, 4, 32'h55, 1);
    drain();
    cmp("t1b");
    chk("t1b_frame_cnt", frame_cnt, 16'd2);

    // single-sample frame
    frame(3, 1, 32'h66, 2);
    drain();
    cmp("t2");
    chk("t2_frame_cnt", frame_cnt, 16'd3);

    // leading counts 2,3 dropped
    send(2, 0, 32'h2, dv(9, 2));
    send(3, 0, 32'h3, dv(9, 3));
    frame(4, 4, 32'h77, 3);
    drain();
    cmp("t3");
    chk("t3_err_cnt", err_cnt, 16'd0);
    chk("t3_frame_cnt", frame_cnt, 16'd4);

    // counts 0,1,3 -> abort
    n_seq = 0;
    ehdr(4, 32'h88);
    esmp(0, 32'h88, dv(10, 0));
    esmp(0, 32'h1, dv(10, 1));
    eabort();
    send(0, 0, 32'h88, dv(10, 0));
    send(1, 0, 32'h1, dv(10, 1));
    send(3, 1, 32'h3, dv(10, 3));
    frame(5, 4, 32'h99, 5);
    drain();
    cmp("t4");
    chk("t4_seq_pulses", 65'(n_seq), 65'd1);
    chk("t4_err_cnt", err_cnt, 16'd1);
    chk("t4_frame_cnt", frame_cnt, 16'd5);

    // 0,1 then restart 0,1,2f
    n_seq = 0;
    ehdr(6, 32'hAA);
    esmp(0, 32'hAA, dv(11, 0));
    esmp(0, 32'h1, dv(11, 1));
    eabort();
    ehdr(7, 32'hBB);
    esmp(0, 32'hBB, dv(12, 0));
    esmp(0, 32'h1, dv(12, 1));
    esmp(1, 32'h2, dv(12, 2));
    send(0, 0, 32'hAA, dv(11, 0));
    send(1, 0, 32'h1, dv(11, 1));
    send(0, 0, 32'hBB, dv(12, 0));
    send(1, 0, 32'h1, dv(12, 1));
    send(2, 1, 32'h2, dv(12, 2));
    drain();
    cmp("t5");
    chk("t5_seq_pulses", 65'(n_seq), 65'd1);
    chk("t5_err_cnt", err_cnt, 16'd2);
    chk("t5_frame_cnt", frame_cnt, 16'd6);

    // random back-pressure, 1000 frames of 8
    rnd_rdy = 1;
    for (int f = 0; f < 1000; f++)
      frame(f, 8, 32'(f + 32'h1000), 8 + f);
    drain();
    rnd_rdy = 0;
    drain();
    cmp("t6");
    chk("t6_err_cnt", err_cnt, 16'd2);
    chk("t6_frame_cnt", frame_cnt, 16'd1006);

    // reset mid-frame restarts frame_seq at 0
    ehdr(1008, 32'h11);
    esmp(0, 32'h11, dv(13, 0));
    esmp(0, 32'h1, dv(13, 1));
    send(0, 0, 32'h11, dv(13, 0));
    send(1, 0, 32'h1, dv(13, 1));
    drain();
    cmp("t7a");
    sync_reset = 1'b1;
    @(posedge clk);
    #1;
    sync_reset = 1'b0;
    frame(14, 2, 32'h22, 0);
    drain();
    cmp("t7b");
    chk("t7_frame_cnt", frame_cnt, 16'd1);
    chk("t7_err_cnt", err_cnt, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
